// File: rtl/param_eval_sched.sv
// param_eval_sched: lazy memoizing evaluator for a table of dependent parameter entries
module param_eval_sched #(
  parameter int N_ENTRIES = 8,
  parameter int WIDTH = 16,
  parameter int IW = $clog2(N_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [1:0]       cfg_op,
  input  logic [IW-1:0]    cfg_ref,
  input  logic [WIDTH-1:0] cfg_imm,
  input  logic             req_valid,
  input  logic [IW-1:0]    req_idx,
  output logic             req_ready,
  output logic             busy,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_value,
  output logic             resp_error
);
  typedef enum logic [1:0] {IDLE, WALK, RESP} state_t;
  state_t state_q, state_d;
  logic [IW:0] sp_q, sp_d, sp_m1;
  logic [IW-1:0] stack_q [N_ENTRIES];
  logic [IW-1:0] stack_d [N_ENTRIES];
  logic [N_ENTRIES-1:0] done_q, done_d, inprog_q, inprog_d;
  logic [WIDTH-1:0] val_q [N_ENTRIES];
  logic [WIDTH-1:0] val_d [N_ENTRIES];
  logic [WIDTH-1:0] imm_q [N_ENTRIES];
  logic [WIDTH-1:0] imm_d [N_ENTRIES];
  logic [1:0] op_q [N_ENTRIES];
  logic [1:0] op_d [N_ENTRIES];
  logic [IW-1:0] ref_q [N_ENTRIES];
  logic [IW-1:0] ref_d [N_ENTRIES];
  logic [WIDTH-1:0] res_q, res_d;
  logic err_q, err_d;
  logic [IW-1:0] top, tref;
  logic [1:0] top_op;
  logic [WIDTH-1:0] rv, timm, calc;
  assign req_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_value = res_q;
  assign resp_error = err_q;
  // Shared arithmetic unit: evaluates the entry on top of the stack from its referenced cache value
  always_comb begin
    sp_m1 = sp_q - 1'b1;
    top = stack_q[sp_m1[IW-1:0]];
    top_op = op_q[top];
    tref = ref_q[top];
    timm = imm_q[top];
    rv = val_q[tref];
    calc = top_op == 2'd0 ? timm : top_op == 2'd1 ? rv + timm : top_op == 2'd2 ? rv * timm : rv * rv + timm;
  end
  // Next-state: config writes in IDLE, one stack action per WALK cycle, cleanup in RESP
  always_comb begin
    state_d = state_q;
    sp_d = sp_q;
    stack_d = stack_q;
    done_d = done_q;
    inprog_d = inprog_q;
    val_d = val_q;
    imm_d = imm_q;
    op_d = op_q;
    ref_d = ref_q;
    res_d = res_q;
    err_d = err_q;
    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          op_d[cfg_idx] = cfg_op;
          ref_d[cfg_idx] = cfg_ref;
          imm_d[cfg_idx] = cfg_imm;
          done_d = '0;
        end
        if (req_valid) begin
          stack_d[0] = req_idx;
          sp_d = 1;
          inprog_d[req_idx] = 1'b1;
          state_d = WALK;
        end
      end
      WALK: begin
        if (done_q[top] || top_op == 2'd0 || done_q[tref]) begin
          if (!done_q[top]) begin
            val_d[top] = calc;
            done_d[top] = 1'b1;
          end
          inprog_d[top] = 1'b0;
          sp_d = sp_m1;
          if (sp_m1 == '0) begin
            state_d = RESP;
            res_d = done_q[top] ? val_q[top] : calc;
          end
        end else if (inprog_q[tref]) begin
          state_d = RESP;
          err_d = 1'b1;
          res_d = '0;
        end else begin
          stack_d[sp_q[IW-1:0]] = tref;
          sp_d = sp_q + 1'b1;
          inprog_d[tref] = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        inprog_d = '0;
        sp_d = '0;
        err_d = 1'b0;
        res_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers; reset returns every entry to CONST 0 and aborts any walk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sp_q <= '0;
      done_q <= '0;
      inprog_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        stack_q[i] <= '0;
        val_q[i] <= '0;
        imm_q[i] <= '0;
        op_q[i] <= '0;
        ref_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      sp_q <= sp_d;
      done_q <= done_d;
      inprog_q <= inprog_d;
      res_q <= res_d;
      err_q <= err_d;
      stack_q <= stack_d;
      val_q <= val_d;
      imm_q <= imm_d;
      op_q <= op_d;
      ref_q <= ref_d;
    end
  end
endmodule
